// File: rtl/parity_scrub_ctrl.sv
// parity_scrub_ctrl: background parity scrubber and read-port arbiter for the raw-hits RAMs
// Ports: clock/global_reset_n (sync, active-low); perr_reset clears error stats;
//   scrub_en/perr_en enable scanning; perr is the RAM parity summary, RD_LAT after the address;
//   seq_rd_req/seq_rd_adr is the sequencer read, which always wins the port;
//   ram_rd_adr/ram_rd_scrub drive the RAM read port; scrub_* report status and counters.
// Optional: define SCRUB_STOP_ON_ERR_EN to halt scanning after the first scrub error.
module parity_scrub_ctrl #(
  parameter int RAM_ADRB      = 11,
  parameter int RD_LAT        = 2,
  parameter int SCAN_GAP      = 4,
  parameter int PERR_CNT_BITS = 16,
  parameter int PASS_CNT_BITS = 8
) (
  input  logic                     clock,
  input  logic                     global_reset_n,
  input  logic                     perr_reset,
  input  logic                     scrub_en,
  input  logic                     perr_en,
  input  logic                     perr,
  input  logic                     seq_rd_req,
  input  logic [RAM_ADRB-1:0]      seq_rd_adr,
  output logic [RAM_ADRB-1:0]      ram_rd_adr,
  output logic                     ram_rd_scrub,
  output logic                     scrub_busy,
  output logic                     scrub_pass_done,
  output logic [PASS_CNT_BITS-1:0] scrub_pass_cnt,
  output logic [PERR_CNT_BITS-1:0] scrub_perr_cnt,
  output logic                     scrub_first_vld,
  output logic [RAM_ADRB-1:0]      scrub_first_adr
);
  localparam int GW = SCAN_GAP > 1 ? $clog2(SCAN_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(SCAN_GAP - 1);
`ifdef SCRUB_STOP_ON_ERR_EN
  typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DRAIN} state_t;
`endif
  state_t state, nxt;
  logic [RAM_ADRB-1:0] scrub_adr;
  logic [GW-1:0] gap_cnt;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0][RAM_ADRB-1:0] pipe_adr;
  logic abort, done_pend, halt_req, adr_clr;
  wire go         = scrub_en && perr_en;
  wire issue      = state == ISSUE && !seq_rd_req;
  wire last       = &scrub_adr;
  wire pipe_empty = ~|pipe_vld;
  wire drain_end  = state == DRAIN && pipe_empty;
  wire scrub_err  = pipe_vld[RD_LAT-1] && perr;
  assign scrub_busy = state != IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = go ? ISSUE : IDLE;
      ISSUE: nxt = (!go || halt_req || (issue && last)) ? DRAIN : (issue && SCAN_GAP != 0) ? GAP : ISSUE;
      GAP:   nxt = (!go || halt_req) ? DRAIN : gap_cnt == GAP_LAST ? ISSUE : GAP;
      DRAIN: begin
        nxt = !pipe_empty ? DRAIN : (abort || !go) ? IDLE : ISSUE;
`ifdef SCRUB_STOP_ON_ERR_EN
        if (pipe_empty && !abort && halt_req) nxt = HALT;
`endif
      end
`ifdef SCRUB_STOP_ON_ERR_EN
      HALT:  nxt = !scrub_en ? IDLE : perr_reset ? ISSUE : HALT;
`endif
      default: nxt = IDLE;
    endcase
  end
  // A halted scan keeps its address so perr_reset can resume where it stopped.
`ifdef SCRUB_STOP_ON_ERR_EN
  assign adr_clr = (drain_end && nxt != HALT) || (state == HALT && !scrub_en);
  always_ff @(posedge clock)
    if (!global_reset_n) halt_req <= 1'b0;
    else if ((state == HALT && nxt != HALT) || (drain_end && abort)) halt_req <= 1'b0;
    else if (scrub_err && !perr_reset) halt_req <= 1'b1;
`else
  assign adr_clr  = drain_end;
  assign halt_req = 1'b0;
`endif
  always_ff @(posedge clock) begin
    for (int i = RD_LAT - 1; i > 0; i--) pipe_adr[i] <= pipe_adr[i-1];
    pipe_adr[0] <= scrub_adr;
  end
  always_ff @(posedge clock) begin
    if (!global_reset_n) begin
      state           <= IDLE;
      scrub_adr       <= '0;
      gap_cnt         <= '0;
      pipe_vld        <= '0;
      abort           <= 1'b0;
      done_pend       <= 1'b0;
      ram_rd_adr      <= '0;
      ram_rd_scrub    <= 1'b0;
      scrub_pass_done <= 1'b0;
      scrub_pass_cnt  <= '0;
      scrub_perr_cnt  <= '0;
      scrub_first_vld <= 1'b0;
      scrub_first_adr <= '0;
    end else begin
      state        <= nxt;
      ram_rd_adr   <= seq_rd_req ? seq_rd_adr : issue ? scrub_adr : ram_rd_adr;
      ram_rd_scrub <= issue;
      for (int i = RD_LAT - 1; i > 0; i--) pipe_vld[i] <= pipe_vld[i-1];
      pipe_vld[0]  <= issue;
      scrub_adr    <= issue ? scrub_adr + 1'b1 : adr_clr ? '0 : scrub_adr;
      gap_cnt      <= state == GAP ? gap_cnt + 1'b1 : '0;
      // abort marks a pass cut short by a dropped enable; it must not count as done
      abort        <= ((state == ISSUE || state == GAP) && !go) ? 1'b1 : drain_end ? 1'b0 : abort;
      done_pend    <= (issue && last) ? 1'b1 : drain_end ? 1'b0 : done_pend;
      scrub_pass_done <= drain_end && done_pend && !abort;
      scrub_pass_cnt  <= scrub_pass_cnt + PASS_CNT_BITS'(drain_end && done_pend && !abort);
      if (perr_reset) begin
        scrub_perr_cnt  <= '0;
        scrub_first_vld <= 1'b0;
        scrub_first_adr <= '0;
      end else if (scrub_err) begin
        scrub_perr_cnt <= &scrub_perr_cnt ? scrub_perr_cnt : scrub_perr_cnt + 1'b1;
        if (!scrub_first_vld) begin
          scrub_first_vld <= 1'b1;
          scrub_first_adr <= pipe_adr[RD_LAT-1];
        end
      end
    end
  end
endmodule

// File: doc/parity_scrub_ctrl.md
Name: parity_scrub_ctrl

Overview:
- Background scrubber and read-port arbiter for the CFEB/RPC/miniscope raw-hits RAMs.
- Walks every RAM address in idle read slots, using the RAMs' shared parity-error summary to find latent errors before the sequencer reads them.
- The sequencer readout always has priority on the shared read port.
- Sits beside the parity summary logic and feeds scrub status and counters to VME.

Parameters:
RAM_ADRB, 11, RAM address width; one pass covers 2^RAM_ADRB addresses
RD_LAT, 2, cycles from read-address register to valid perr (min 1, max 4)
SCAN_GAP, 4, idle cycles inserted after each scrub read (0 = back-to-back)
PERR_CNT_BITS, 16, width of the scrub error counter
PASS_CNT_BITS, 8, width of the completed-pass counter

Ports:
clock  in  1  40MHz TMB main clock
global_reset_n  in  1  synchronous active-low reset
perr_reset  in  1  active-high pulse; clears error counter and first-error capture
scrub_en  in  1  VME enable for background scrubbing
perr_en  in  1  parity latch enabled (all addresses written at least once)
perr  in  1  RAM parity-error summary, valid RD_LAT cycles after the address
seq_rd_req  in  1  sequencer requests read port this cycle
seq_rd_adr  in  RAM_ADRB  sequencer read address
ram_rd_adr  out  RAM_ADRB  registered read address to RAMs
ram_rd_scrub  out  1  registered; 1 = current read slot owned by the scrubber
scrub_busy  out  1  pass in progress
scrub_pass_done  out  1  one-cycle pulse at pass completion
scrub_pass_cnt  out  PASS_CNT_BITS  completed passes, wraps
scrub_perr_cnt  out  PERR_CNT_BITS  scrub parity errors, saturates at all-ones
scrub_first_vld  out  1  scrub_first_adr holds a valid address
scrub_first_adr  out  RAM_ADRB  address of the first scrub error since reset/perr_reset

Behaviour:
- Reset (global_reset_n=0 at a clock edge): every output is 0, the FSM is in IDLE, the scrub address is 0 and the tag pipeline is empty.
- Clock edges with reset active take priority over all other events.
- The scrub address is an internal RAM_ADRB counter.
- Arbitration, on each edge:
  - If seq_rd_req: ram_rd_adr<=seq_rd_adr and ram_rd_scrub<=0.
  - Else if FSM=ISSUE: ram_rd_adr<=scrub address, ram_rd_scrub<=1, a tag carrying that address enters the tag pipeline, and the scrub address increments.
  - Otherwise ram_rd_adr holds its value and ram_rd_scrub<=0.
  - The sequencer is never stalled.
- Tag pipeline, RD_LAT stages:
  - perr is sampled when a scrub tag exits the pipeline, i.e. on edge k+RD_LAT for a read issued at edge k.
  - perr seen during sequencer slots is ignored by this block.
- FSM states and transitions:
  - IDLE -> ISSUE when scrub_en && perr_en. scrub_busy=1 in all states except IDLE.
  - ISSUE: issues one read in the first slot without seq_rd_req, then goes to GAP. After address 2^RAM_ADRB-1 has been issued it goes to DRAIN instead.
  - GAP: counts SCAN_GAP cycles, then returns to ISSUE. With SCAN_GAP=0, ISSUE stays in ISSUE.
  - DRAIN: waits for the tag pipeline to empty. Then pulses scrub_pass_done, increments scrub_pass_cnt and resets the address to 0. It then goes to ISSUE if scrub_en && perr_en, else to IDLE.
- Abort:
  - If scrub_en or perr_en drops in ISSUE or GAP, the FSM goes to DRAIN with an abort flag set.
  - When the pipeline is empty it goes to IDLE and resets the address to 0.
  - An aborted pass produces no pass_done and no pass_cnt increment.
  - Tags still in flight are still checked.
- Error recording:
  - On each scrub error, scrub_perr_cnt increments, saturating at 2^PERR_CNT_BITS-1.
  - On the first scrub error, scrub_first_adr captures the tag's address and scrub_first_vld<=1.
- perr_reset:
  - Clears scrub_perr_cnt, scrub_first_vld and scrub_first_adr. It does not affect the FSM or scrub_pass_cnt.
  - If perr_reset coincides with an error, the clear wins and the error is dropped.
- Counter wrap: scrub_pass_cnt wraps from all-ones to 0.

Optional Feature:
SCRUB_STOP_ON_ERR_EN
- Defined: the first scrub error forces state HALT after the pipeline drains.
  - Later errors from in-flight tags are still counted.
  - In HALT, scrub_busy=1 and no reads are issued; the scrub address freezes at the next address to issue.
  - perr_reset moves HALT to ISSUE and the scan resumes at the frozen address.
  - scrub_en=0 in HALT goes to IDLE and resets the address to 0.
- Undefined: the HALT state does not exist and scanning continues after errors.

Test Plan:
- scrub_en=1, perr_en=1, no seq_rd_req, SCAN_GAP=4 -> 2048 scrub reads spaced 5 cycles apart; scrub_pass_done pulses once; scrub_pass_cnt=1; scrub_perr_cnt=0.
- seq_rd_req held high for 10 cycles mid-pass with seq_rd_adr=0x123 -> ram_rd_adr=0x123 and ram_rd_scrub=0 throughout; the scrub address is unchanged and resumes at the pending address.
- perr forced high only on the cycle tagged for scrub address 0x2A5 (RD_LAT=2) -> scrub_perr_cnt=1, scrub_first_adr=0x2A5, scrub_first_vld=1. A second error at 0x300 -> count=2, first_adr stays 0x2A5.
- scrub_en dropped at scrub address 0x400 -> in-flight tags are checked, then IDLE with no pass_done. Re-enabling restarts at address 0.
- PERR_CNT_BITS=4 with 20 forced errors -> scrub_perr_cnt saturates at 15. perr_reset coinciding with an error -> cnt=0, first_vld=0.
- global_reset_n=0 mid-pass, then with SCRUB_STOP_ON_ERR_EN an error at 0x010 -> after reset all outputs are 0. With the macro: HALT, and after perr_reset reads resume at 0x011.
